mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter that shares the 4-input 1-bit multiplexer (`mux_4x1`) between four requesters. It samples four request lines, grants the channel to exactly one requester at a time, and drives the mux select so that the granted requester's data reaches `Y`. It enforces a bounded hold time per grant, so a requester that never releases cannot starve the others. It sits directly in front of `mux_4x1`: `sel` connects to the mux `s` input, and `grant` goes back to the requesters.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles a grant is held while another requester is waiting; legal range 1..15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  input  4  request lines; `req[i]` high means requester i wants the channel; level-sensitive.
- `grant`  output  4  registered one-hot grant; all zero when idle.
- `sel`  output  2  registered index of the current or most recent owner; drives `mux_4x1` `s`.
- `busy`  output  1  registered; high exactly when `grant != 0`.

## Operation
- Internal state:
  - FSM with states IDLE and OWN.
  - 2-bit `last` pointer (most recent owner).
  - 4-bit `hold_cnt`.
- Reset (`rst_n`=0 at an edge): state=IDLE, `grant`=0000, `sel`=00, `busy`=0, `last`=3, `hold_cnt`=0. Reset overrides all other activity, including a reset that arrives mid-grant.
- Rotation search from pointer p: check p+1, p+2, p+3, p (mod 4) and pick the first set `req` bit. After reset, `last`=3, so requester 0 has top priority.
- IDLE:
  - `req`=0000: stay in IDLE; `sel` keeps its previous value so the mux output stays stable.
  - Any `req` set: winner w = rotation search from `last`. Next edge: `grant`=onehot(w), `sel`=w, `busy`=1, `hold_cnt`=1, state=OWN.
- OWN, owner o, evaluated every edge:
  - `req[o]`=0 (release): `last`=o.
    - Other requests pending: grant winner from rotation search starting at o in the same edge, with no idle bubble; `hold_cnt`=1.
    - Otherwise: `grant`=0000, `busy`=0, state=IDLE, `sel` holds o.
  - `req[o]`=1, another request pending, `hold_cnt`==`MAX_HOLD` (preempt): `last`=o, grant next winner from rotation search starting at o, excluding o; `hold_cnt`=1.
  - `req[o]`=1, another request pending, `hold_cnt`<`MAX_HOLD`: keep grant; `hold_cnt`+=1.
  - `req[o]`=1, no other request: keep grant; `hold_cnt` saturates at `MAX_HOLD` (no wrap). If another request later appears with `hold_cnt` already at `MAX_HOLD`, preemption happens on that same edge.
- Invariants:
  - `grant` is always zero or one-hot.
  - `grant` is never given to a requester whose `req` bit was 0 at the deciding edge.
  - `sel` always equals the index of the set `grant` bit when `busy`=1.
- Arithmetic: pointer and index math is modulo 4 on 2 bits. `hold_cnt` is 4 bits, and comparison against `MAX_HOLD` is unsigned.

## Timing
- Latency, request to grant: 1 cycle. A `req` bit sampled at edge k with the arbiter idle gives `grant`/`sel`/`busy` valid after edge k.
- Latency, release to handover: 1 cycle. The `req[o]` drop is sampled at edge k, and the new grant or idle state appears after edge k.
- A requester holds the channel for at most `MAX_HOLD` consecutive cycles while others wait. Worst-case wait for any continuously requesting input is 3*`MAX_HOLD` cycles plus 1 cycle.
- All outputs are registered and glitch-free. There are no combinational paths from `req` to any output.
- Simultaneous events on one edge:
  - Release by the owner plus new requests: handover on that edge.
  - `rst_n`=0 together with any `req`: reset wins.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=1111, then release. Required: `grant`=0000, `sel`=00, `busy`=0 during reset; `grant`=0001, `sel`=00 one cycle after release.
- Single requester: `req`=0100 for 3 cycles, then 0000. Required: `grant`=0100, `sel`=10 from cycle 1; after the drop, `grant`=0000, `busy`=0, `sel` stays 10.
- Fair rotation, `MAX_HOLD`=4: `req`=1111 held for 20 cycles. Required: grants 0001, 0010, 0100, 1000, 0001, each lasting exactly 4 cycles; `sel` follows 00, 01, 10, 11, 00.
- Early release handover: owner 1 (`req`=0010), then `req`=1001 with bit 1 dropped in the same cycle. Required: next `grant`=1000 (search from 1 gives 2, 3 → 3), with no idle cycle between grants.
- Saturation then preempt: `req`=0001 for 10 cycles, then `req`=0011. Required: grant 0001 throughout the first 10 cycles, then `grant`=0010 on the first edge that samples 0011.
- Reset mid-grant: with owner 2, assert `rst_n`=0 for 1 cycle while `req`=0100. Required: all outputs cleared on that edge; after release, `grant` returns to 0100 (the only requester).
- Mux integration: drive `mux_4x1` with `sel`, data a=1, b=c=d=0, `req`=0011. Required: `Y`=1 while `grant`=0001, and `Y`=0 while `grant`=0010.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4:1 one-bit mux.
// It grants one of four level-sensitive requesters at a time and rotates
// priority fairly. While others are waiting, a grant lasts at most MAX_HOLD
// consecutive cycles. All outputs are registered, so there is no
// combinational path from req_i to any output.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       busy_o
);

    localparam logic [3:0] MaxHoldC = 4'(MAX_HOLD);

    typedef enum logic [0:0] {
        StIdle,
        StOwn
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] hold_q,  hold_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;

    // Owner bookkeeping, valid while in StOwn.
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic       owner_req;

    // Returns the first set bit of r in the order p+1, p+2, p+3, p (mod 4).
    // The loop runs from the lowest priority to the highest, so the last hit
    // it records is the winner.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        win = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    assign owner_oh  = 4'b0001 << sel_q;
    assign others    = req_i & ~owner_oh;
    assign owner_req = |(req_i & owner_oh);

    // State register plus registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: leave StOwn only when the owner releases with nobody waiting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (!owner_req && !(|others)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant, select, pointer and hold-counter updates for the next edge.
    always_comb begin
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                // With no request, sel stays put so the mux output does not move.
                if (|req_i) begin
                    sel_d   = rr_pick(req_i, last_q);
                    grant_d = 4'b0001 << rr_pick(req_i, last_q);
                    busy_d  = 1'b1;
                    hold_d  = 4'd1;
                end
            end
            StOwn: begin
                if (!owner_req) begin
                    last_d = sel_q;
                    if (|others) begin
                        // Hand over on the same edge; no idle bubble.
                        sel_d   = rr_pick(others, sel_q);
                        grant_d = 4'b0001 << rr_pick(others, sel_q);
                        hold_d  = 4'd1;
                    end else begin
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else if (|others) begin
                    if (hold_q >= MaxHoldC) begin
                        // Preempt: the owner is masked out of the search.
                        last_d  = sel_q;
                        sel_d   = rr_pick(others, sel_q);
                        grant_d = 4'b0001 << rr_pick(others, sel_q);
                        hold_d  = 4'd1;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end else if (hold_q < MaxHoldC) begin
                    // Sole requester: count up and saturate, so a later
                    // contender can preempt on the first edge it is seen.
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign busy_o  = busy_q;

endmodule
